// File: rtl/spi_exe_frame_rx.sv
// spi_exe_frame_rx
// SPI slave (mode 0) front-end for exe_unit. Deserialises a {argA, argB, oper}
// command frame, presents it with a one-cycle o_valid pulse, captures exe_unit's
// result and flags, and returns them on MISO during the following frame.
// All SPI pins are oversampled by i_clk.
//
// Ports:
//   i_clk, i_rst            system clock, async active-high reset
//   i_sclk, i_cs_n, i_mosi  SPI pins from the master (asynchronous)
//   o_miso                  SPI data out, MSB first, 0 while cs_n is high
//   o_argA, o_argB, o_oper  operands to exe_unit, stable between o_valid pulses
//   o_valid                 one-cycle pulse, new operands
//   o_frame_err             one-cycle pulse, frame discarded (bad bit count)
//   i_result, i_OF..i_VF    exe_unit result and flags
module spi_exe_frame_rx #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_sclk,
  input  logic         i_cs_n,
  input  logic         i_mosi,
  output logic         o_miso,
  output logic [M-1:0] o_argA,
  output logic [M-1:0] o_argB,
  output logic [N-1:0] o_oper,
  output logic         o_valid,
  output logic         o_frame_err,
  input  logic [M-1:0] i_result,
  input  logic         i_OF,
  input  logic         i_SF,
  input  logic         i_BF,
  input  logic         i_VF
);

  localparam int FRAME_BITS = 2 * M + N;
  localparam int RESP_BITS  = M + 4;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_t;

  // Synchronisers: bit0 = stage 1, bit1 = stage 2, bit2 = edge-detect stage.
  logic [2:0] r_sclk_sync;
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[1:0], i_cs_n};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
    end
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_BITS-1:0] r_rx;
  logic [RESP_BITS-2:0]  r_tx;       // bits still to send after the current MSB
  logic [RESP_BITS-1:0]  r_resp;
  logic                  r_cap;      // capture exe_unit outputs this cycle
  logic                  r_miso;
  logic [M-1:0]          r_arg_a;
  logic [M-1:0]          r_arg_b;
  logic [N-1:0]          r_oper;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_fall_pend;  // cs_n fall seen in DONE, start on next IDLE
  logic [1:0]            r_flush;      // sync chain still holds reset presets
  logic                  r_armed;      // cs_n seen high since reset

  // Bypass a same-cycle capture so a frame starting right away sends fresh data.
  logic [RESP_BITS-1:0] w_resp_next;
  assign w_resp_next = r_cap ? {i_result, i_OF, i_SF, i_BF, i_VF} : r_resp;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_resp      <= '0;
      r_cap       <= 1'b0;
      r_miso      <= 1'b0;
      r_arg_a     <= '0;
      r_arg_b     <= '0;
      r_oper      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_fall_pend <= 1'b0;
      r_flush     <= 2'd0;
      r_armed     <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_cap       <= r_valid;
      r_resp      <= w_resp_next;

      // A frame already running when reset is released must be skipped, so only
      // accept a start after cs_n has genuinely been observed high.
      if (r_flush != 2'd2) begin
        r_flush <= r_flush + 2'd1;
      end else if (r_cs_sync[1]) begin
        r_armed <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (r_armed && (w_cs_fall || r_fall_pend)) begin
            r_state     <= StRecv;
            r_cnt       <= '0;
            r_tx        <= w_resp_next[RESP_BITS-2:0];
            r_miso      <= w_resp_next[RESP_BITS-1];
            r_fall_pend <= 1'b0;
          end else begin
            r_miso <= 1'b0;
          end
        end
        StRecv: begin
          // cs_n rise has priority; a coincident sclk edge is dropped.
          if (w_cs_rise) begin
            r_state <= StDone;
            r_miso  <= 1'b0;
            if (r_cnt == CNT_W'(FRAME_BITS)) begin
              r_arg_a <= r_rx[FRAME_BITS-1 -: M];
              r_arg_b <= r_rx[N +: M];
              r_oper  <= r_rx[N-1:0];
              r_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            if (w_sclk_rise) begin
              r_rx <= {r_rx[FRAME_BITS-2:0], r_mosi_sync[1]};
              if (r_cnt != CNT_W'(FRAME_BITS + 1)) begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            if (w_sclk_fall) begin
              r_miso <= r_tx[RESP_BITS-2];
              r_tx   <= {r_tx[RESP_BITS-3:0], 1'b0};
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          if (w_cs_fall) begin
            r_fall_pend <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_miso      = r_miso & ~i_cs_n;
  assign o_argA      = r_arg_a;
  assign o_argB      = r_arg_b;
  assign o_oper      = r_oper;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_exe_frame_rx.sv
// Testbench for spi_exe_frame_rx: table of SPI frames driven at SCLK = clk/8,
// expected operand/error events queued at cs_n rise and checked when the DUT
// pulses o_valid / o_frame_err; MISO bits compared against a response model.
module tb_spi_exe_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] result = 8'h00;
  logic [3:0] flags = 4'h0;
  logic       o_miso;
  logic [7:0] o_argA;
  logic [7:0] o_argB;
  logic [3:0] o_oper;
  logic       o_valid;
  logic       o_frame_err;

  spi_exe_frame_rx dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sclk     (sclk),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .o_miso     (o_miso),
    .o_argA     (o_argA),
    .o_argB     (o_argB),
    .o_oper     (o_oper),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .i_result   (result),
    .i_OF       (flags[3]),
    .i_SF       (flags[2]),
    .i_BF       (flags[1]),
    .i_VF       (flags[0])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic [7:0]  res;
    logic [3:0]  flg;
    int          gap;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    int         t;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  last_a = 8'h00;
  logic [7:0]  last_b = 8'h00;
  logic [3:0]  last_op = 4'h0;
  logic [11:0] exp_resp = 12'h000;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit: data set at start of low phase, MISO sampled just before the rise.
  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    clks(4);
    m = o_miso;
    sclk = 1'b1;
    clks(4);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    logic [31:0] cap;
    logic [31:0] exp_miso;
    logic        m;
    ev_t         e;
    cap = '0;
    cs_n = 1'b0;
    clks(8);
    result = v.res;
    flags  = v.flg;
    for (int i = v.nbits - 1; i >= 0; i--) begin
      spi_bit(v.data[i], m);
      cap = {cap[30:0], m};
    end
    clks(4);
    cs_n = 1'b1;
    e.err = (v.nbits != 20);
    if (!e.err) begin
      last_a  = v.data[19:12];
      last_b  = v.data[11:4];
      last_op = v.data[3:0];
    end
    e.a  = last_a;
    e.b  = last_b;
    e.op = last_op;
    e.t  = cyc;
    sb.push_back(e);
    if (v.nbits >= 12) exp_miso = {20'b0, exp_resp} << (v.nbits - 12);
    else exp_miso = {20'b0, exp_resp} >> (12 - v.nbits);
    chk("miso_frame", cap, exp_miso);
    if (!e.err) exp_resp = {v.res, v.flg};
    clks(1);
    chk("miso_cs_high", {31'b0, o_miso}, 32'd0);
    clks(v.gap - 1);
  endtask

  // Scoreboard side: every output event must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && (o_valid || o_frame_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'b0, o_valid, o_frame_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", {30'b0, o_valid, o_frame_err}, mon_e.err ? 32'd1 : 32'd2);
        chk("latency", cyc - mon_e.t, 32'd3);
        chk("argA", {24'b0, o_argA}, {24'b0, mon_e.a});
        chk("argB", {24'b0, o_argB}, {24'b0, mon_e.b});
        chk("oper", {28'b0, o_oper}, {28'b0, mon_e.op});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d checks, required completion", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    logic rb;
    logic [31:0] fr;

    tbl[0] = '{data: 32'h3C051, nbits: 20, res: 8'h41, flg: 4'h2, gap: 12};
    tbl[1] = '{data: 32'hFF017, nbits: 20, res: 8'h5A, flg: 4'h9, gap: 12};
    tbl[2] = '{data: 32'h00ABC, nbits: 12, res: 8'h77, flg: 4'hF, gap: 12};
    tbl[3] = '{data: 32'h0A5A5A, nbits: 21, res: 8'h66, flg: 4'hE, gap: 12};
    tbl[4] = '{data: 32'h12345, nbits: 20, res: 8'hC3, flg: 4'h6, gap: 4};
    tbl[5] = '{data: 32'hABCDE, nbits: 20, res: 8'h3E, flg: 4'h1, gap: 12};

    clks(3);
    chk("rst_argA", {24'b0, o_argA}, 32'd0);
    chk("rst_argB", {24'b0, o_argB}, 32'd0);
    chk("rst_oper", {28'b0, o_oper}, 32'd0);
    chk("rst_valid_err", {30'b0, o_valid, o_frame_err}, 32'd0);
    chk("rst_miso", {31'b0, o_miso}, 32'd0);
    rst = 1'b0;
    clks(6);

    for (int i = 0; i < 6; i++) send_frame(tbl[i]);
    chk("final_argA", {24'b0, o_argA}, 32'hAB);
    chk("final_oper", {28'b0, o_oper}, 32'hE);

    // Reset after 10 bits, then finish the frame: it must be ignored.
    fr = 32'h3C051;
    cs_n = 1'b0;
    clks(8);
    for (int i = 19; i >= 10; i--) spi_bit(fr[i], m);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    last_a = 8'h00;
    last_b = 8'h00;
    last_op = 4'h0;
    exp_resp = 12'h000;
    chk("midrst_argA", {24'b0, o_argA}, 32'd0);
    chk("midrst_argB", {24'b0, o_argB}, 32'd0);
    chk("midrst_oper", {28'b0, o_oper}, 32'd0);
    for (int i = 9; i >= 0; i--) begin
      spi_bit(fr[i], m);
      chk("midrst_miso", {31'b0, m}, 32'd0);
    end
    clks(4);
    cs_n = 1'b1;
    clks(12);
    chk("midrst_argA_after", {24'b0, o_argA}, 32'd0);
    send_frame('{data: 32'h3C051, nbits: 20, res: 8'h11, flg: 4'h8, gap: 12});

    // SCLK toggling with cs_n high must be ignored.
    for (int i = 0; i < 30; i++) begin
      rb = 1'($urandom_range(1, 0));
      spi_bit(rb, m);
      chk("idle_miso", {31'b0, m}, 32'd0);
    end
    clks(8);
    send_frame('{data: 32'hBEEF1, nbits: 20, res: 8'h00, flg: 4'h0, gap: 12});

    clks(10);
    chk("sb_empty", sb.size(), 32'd0);
    chk("end_argA", {24'b0, o_argA}, 32'hBE);
    chk("end_argB", {24'b0, o_argB}, 32'hEF);
    chk("end_oper", {28'b0, o_oper}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
